trg_gtx_tx_sync: RTL and testbench
==================================

TRG_GTX_TX_SYNC -- requirements
Module: trg_gtx_tx_sync

Interface
REQ-001 Parameter DLY_RST_CYC, default 16, meaning cycles TXDLYALIGNRESET is held high.
REQ-002 Parameter SETTLE_CYC, default 32, meaning settle cycles between delay-align reset and phase set.
REQ-003 Parameter PHS_ALIGN_CYC, default 8192, meaning cycles TXPMASETPHASE is held high.
REQ-004 Parameter TIMEOUT_CYC, default 16000, meaning cycles allowed for TX_RESETDONE before TIMEOUT.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: CLK  in  1  fabric/TXUSRCLK2-domain clock; RST  in  1  synchronous active-high reset.
REQ-006 GTX_RST  in  1  GTX reset from the trigger-clock start FSM; high holds this block idle.
REQ-007 TX_RESETDONE  in  1  GTX TX reset-done, already synchronous to CLK.
REQ-008 TXENPMAPHASEALIGN  out  1  GTX PMA phase-align enable.
REQ-009 TXPMASETPHASE  out  1  GTX PMA set-phase strobe.
REQ-010 TXDLYALIGNRESET  out  1  GTX TX delay-aligner reset.
REQ-011 TXDLYALIGNDISABLE  out  1  GTX TX delay-aligner disable.
REQ-012 SYNC_DONE  out  1  TX phase alignment complete; feeds the start FSM SYNC_DONE input.
REQ-013 TIMEOUT  out  1  one-cycle pulse when TX_RESETDONE wait expires.

Function
REQ-014 States SHALL be Idle, W4RstDone, DlyRst, Settle, PhsAlign, Done; all outputs registered, decoded from next state.
REQ-015 A single 14-bit up-counter SHALL time all states; cleared on every state entry; every parameter SHALL be 1..16383.
REQ-016 From any state, GTX_RST=1 SHALL force Idle next cycle; GTX_RST priority over all other conditions except RST.
REQ-017 Idle -> W4RstDone when GTX_RST=0.
REQ-018 W4RstDone -> DlyRst when TX_RESETDONE=1.
REQ-019 DlyRst: TXDLYALIGNRESET=1 and TXENPMAPHASEALIGN=1 for exactly DLY_RST_CYC cycles, then Settle.
REQ-020 Settle: TXENPMAPHASEALIGN=1 only, for exactly SETTLE_CYC cycles, then PhsAlign.
REQ-021 PhsAlign: TXENPMAPHASEALIGN=1 and TXPMASETPHASE=1 for exactly PHS_ALIGN_CYC cycles, then Done.
REQ-022 Done: SYNC_DONE=1, TXENPMAPHASEALIGN=1, TXDLYALIGNDISABLE=0; held while TX_RESETDONE=1 and GTX_RST=0.
REQ-023 TXDLYALIGNDISABLE SHALL be 1 in every state except Done.
REQ-024 TX_RESETDONE falling in DlyRst, Settle, PhsAlign or Done SHALL return to W4RstDone next cycle, SYNC_DONE low that cycle.
REQ-025 SYNC_DONE SHALL rise first cycle after the last PhsAlign cycle, i.e. DLY_RST_CYC+SETTLE_CYC+PHS_ALIGN_CYC+1 cycles after TX_RESETDONE is sampled high.

Reset
REQ-026 RST=1 at a CLK edge SHALL set state Idle, counter 0, TXDLYALIGNDISABLE=1, all other outputs 0, including mid-sequence.
REQ-027 RST SHALL take priority over GTX_RST and all inputs.

Configuration
REQ-028 Macro TRG_SYNC_TIMEOUT_EN: when defined, W4RstDone lasting TIMEOUT_CYC cycles SHALL pulse TIMEOUT one cycle and restart the wait count, state unchanged.
REQ-029 Without TRG_SYNC_TIMEOUT_EN, TIMEOUT SHALL be constant 0 and W4RstDone SHALL wait indefinitely; port list unchanged.

Structure
REQ-030 State encodings and the 14-bit counter width constant SHALL live in shared package trg_clk_pkg, alongside the start FSM encodings.
REQ-031 One sub-module, trg_sync_cnt (loadable-clear 14-bit counter with terminal-count compare), is natural; the FSM stays in the top.

Verification
REQ-032 RST high 3 cycles, GTX_RST=1 -> TXDLYALIGNDISABLE=1, other outputs 0, SYNC_DONE never rises.
REQ-033 GTX_RST falls, TX_RESETDONE rises at cycle 10, defaults -> TXDLYALIGNRESET high 16 cycles, TXPMASETPHASE high 8192 cycles, SYNC_DONE rises 8241 cycles after TX_RESETDONE sampled.
REQ-034 TX_RESETDONE drops at PhsAlign cycle 100 -> W4RstDone next cycle, TXPMASETPHASE 0; re-rise restarts full sequence from DlyRst.
REQ-035 GTX_RST pulses high in Done -> SYNC_DONE 0 next cycle, Idle; sequence restarts after GTX_RST falls.
REQ-036 TRG_SYNC_TIMEOUT_EN defined, TIMEOUT_CYC=100, TX_RESETDONE held 0 -> TIMEOUT pulses 1 cycle every 100 cycles; undefined -> TIMEOUT stays 0.
REQ-037 Overrides DLY_RST_CYC=1, SETTLE_CYC=1, PHS_ALIGN_CYC=1 -> each strobe high exactly 1 cycle, SYNC_DONE 4 cycles after TX_RESETDONE sampled.

Source files
------------

// File: rtl/trg_clk_pkg.sv
// Shared encodings for the trigger-clock start FSM and the GTX TX sync FSM.
// Also holds the width of the shared sync timing counter.
package trg_clk_pkg;

   localparam int CNT_W = 14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W4_RST_DONE,
      S_DLY_RST,
      S_SETTLE,
      S_PHS_ALIGN,
      S_DONE
   } sync_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GTX_RST,
      ST_W4_SYNC,
      ST_RUN
   } start_state_t;

endpackage

// File: rtl/trg_sync_cnt.sv
// Clearable up-counter with a terminal-count compare.
// The caller supplies the terminal value for the current state.
module trg_sync_cnt
   import trg_clk_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] tc_val,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] ONE = 1;

   // count up, restart from zero on reset or clear
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else            cnt <= cnt + ONE;
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/trg_gtx_tx_sync.sv
// GTX TX phase-alignment sequencer: delay-align reset, settle, set-phase, done.
// Optional TX_RESETDONE wait timeout pulse enabled by TRG_SYNC_TIMEOUT_EN.
module trg_gtx_tx_sync
   import trg_clk_pkg::*;
#(
   parameter int DLY_RST_CYC   = 16,
   parameter int SETTLE_CYC    = 32,
   parameter int PHS_ALIGN_CYC = 8192,
   parameter int TIMEOUT_CYC   = 16000
) (
   input  logic CLK,
   input  logic RST,
   input  logic GTX_RST,
   input  logic TX_RESETDONE,
   output logic TXENPMAPHASEALIGN,
   output logic TXPMASETPHASE,
   output logic TXDLYALIGNRESET,
   output logic TXDLYALIGNDISABLE,
   output logic SYNC_DONE,
   output logic TIMEOUT
);

   localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(DLY_RST_CYC - 1);
   localparam logic [CNT_W-1:0] SET_TC = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] PHS_TC = CNT_W'(PHS_ALIGN_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(TIMEOUT_CYC - 1);

   sync_state_t      state;
   sync_state_t      nxt;
   logic             tmo_nxt;
   logic             clr;
   logic             tc;
   logic [CNT_W-1:0] tc_val;
   logic [CNT_W-1:0] cnt;

   trg_sync_cnt u_cnt (
      .clk    (CLK),
      .rst    (RST),
      .clr    (clr),
      .tc_val (tc_val),
      .cnt    (cnt),
      .tc     (tc)
   );

   // terminal count for the state currently being timed
   always_comb begin
      tc_val = '1;
      unique case (state)
         S_W4_RST_DONE: tc_val = TMO_TC;
         S_DLY_RST:     tc_val = DLY_TC;
         S_SETTLE:      tc_val = SET_TC;
         S_PHS_ALIGN:   tc_val = PHS_TC;
         default:       tc_val = '1;
      endcase
   end

   // next state, timeout event and counter clear on every state change
   always_comb begin
      nxt     = state;
      tmo_nxt = 1'b0;
      if (GTX_RST) begin
         nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: nxt = S_W4_RST_DONE;
            S_W4_RST_DONE: begin
               if (TX_RESETDONE) nxt = S_DLY_RST;
`ifdef TRG_SYNC_TIMEOUT_EN
               else if (tc) tmo_nxt = 1'b1;
`endif
            end
            S_DLY_RST: begin
               if (!TX_RESETDONE) nxt = S_W4_RST_DONE;
               else if (tc)       nxt = S_SETTLE;
            end
            S_SETTLE: begin
               if (!TX_RESETDONE) nxt = S_W4_RST_DONE;
               else if (tc)       nxt = S_PHS_ALIGN;
            end
            S_PHS_ALIGN: begin
               if (!TX_RESETDONE) nxt = S_W4_RST_DONE;
               else if (tc)       nxt = S_DONE;
            end
            S_DONE: begin
               if (!TX_RESETDONE) nxt = S_W4_RST_DONE;
            end
            default: nxt = S_IDLE;
         endcase
      end
      clr = (nxt != state) || tmo_nxt;
   end

   // state register with outputs decoded from the next state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state             <= S_IDLE;
         TXENPMAPHASEALIGN <= 1'b0;
         TXPMASETPHASE     <= 1'b0;
         TXDLYALIGNRESET   <= 1'b0;
         TXDLYALIGNDISABLE <= 1'b1;
         SYNC_DONE         <= 1'b0;
         TIMEOUT           <= 1'b0;
      end else begin
         state             <= nxt;
         TXENPMAPHASEALIGN <= (nxt == S_DLY_RST) || (nxt == S_SETTLE) ||
                              (nxt == S_PHS_ALIGN) || (nxt == S_DONE);
         TXPMASETPHASE     <= (nxt == S_PHS_ALIGN);
         TXDLYALIGNRESET   <= (nxt == S_DLY_RST);
         TXDLYALIGNDISABLE <= (nxt != S_DONE);
         SYNC_DONE         <= (nxt == S_DONE);
         TIMEOUT           <= tmo_nxt;
      end
   end

endmodule

// File: tb/tb_trg_gtx_tx_sync.sv
// Bench for trg_gtx_tx_sync: default-parameter DUT and a 1/1/1/100 DUT.
// Outputs compared each cycle to an elapsed-time reference model.
module tb_trg_gtx_tx_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic rdone = 1'b0;
   logic g_a = 1'b1;
   logic g_b = 1'b1;

   logic a_en, a_setp, a_dly, a_dis, a_done, a_to;
   logic b_en, b_setp, b_dly, b_dis, b_done, b_to;

`ifdef TRG_SYNC_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   trg_gtx_tx_sync u_a (
      .CLK               (clk),
      .RST               (rst),
      .GTX_RST           (g_a),
      .TX_RESETDONE      (rdone),
      .TXENPMAPHASEALIGN (a_en),
      .TXPMASETPHASE     (a_setp),
      .TXDLYALIGNRESET   (a_dly),
      .TXDLYALIGNDISABLE (a_dis),
      .SYNC_DONE         (a_done),
      .TIMEOUT           (a_to)
   );

   trg_gtx_tx_sync #(
      .DLY_RST_CYC   (1),
      .SETTLE_CYC    (1),
      .PHS_ALIGN_CYC (1),
      .TIMEOUT_CYC   (100)
   ) u_b (
      .CLK               (clk),
      .RST               (rst),
      .GTX_RST           (g_b),
      .TX_RESETDONE      (rdone),
      .TXENPMAPHASEALIGN (b_en),
      .TXPMASETPHASE     (b_setp),
      .TXDLYALIGNRESET   (b_dly),
      .TXDLYALIGNDISABLE (b_dis),
      .SYNC_DONE         (b_done),
      .TIMEOUT           (b_to)
   );

   int errors = 0;
   int checks = 0;
   int sel = 0;
   int md = 16, ms = 32, mp = 8192, mt = 16000;

   // model: idle flag, cycles since sequence start (-1 = waiting), wait count
   bit m_idle = 1'b1;
   int m_act = -1;
   int m_w = 0;
   bit m_to = 1'b0;

   int st_dly, st_phs, st_to;
   logic [5:0] obs;
   int n;

   task automatic chk(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic model(input logic r, input logic g, input logic d);
      m_to = 1'b0;
      if (r || g) begin
         m_idle = 1'b1; m_act = -1; m_w = 0;
      end else if (m_idle) begin
         m_idle = 1'b0; m_act = -1; m_w = 0;
      end else if (m_act < 0) begin
         if (d) m_act = 0;
         else begin
            m_w++;
            if (TO_EN && m_w == mt) begin
               m_to = 1'b1; m_w = 0;
            end
         end
      end else if (!d) begin
         m_act = -1; m_w = 0;
      end else if (m_act < md + ms + mp) begin
         m_act++;
      end
   endtask

   // {en, setphase, dlyreset, disable, done, timeout}
   function automatic logic [5:0] expv();
      if (m_act < 0)         return {5'b00010, m_to};
      if (m_act < md)        return 6'b101100;
      if (m_act < md + ms)   return 6'b100100;
      if (m_act < md+ms+mp)  return 6'b110100;
      return 6'b100010;
   endfunction

   task automatic cyc(input logic r, input logic g, input logic d);
      rst = r;
      rdone = d;
      if (sel == 0) begin g_a = g; g_b = 1'b1; end
      else          begin g_b = g; g_a = 1'b1; end
      @(posedge clk);
      model(r, g, d);
      #1;
      obs = (sel == 0) ? {a_en, a_setp, a_dly, a_dis, a_done, a_to}
                       : {b_en, b_setp, b_dly, b_dis, b_done, b_to};
      if (obs[3]) st_dly++;
      if (obs[4]) st_phs++;
      if (obs[0]) st_to++;
      chk("outputs", int'(obs), int'(expv()));
   endtask

   task automatic run_done(input string tag);
      int k;
      k = 0;
      st_dly = 0; st_phs = 0;
      do begin
         cyc(1'b0, 1'b0, 1'b1);
         k++;
      end while (!obs[1] && k < md + ms + mp + 50);
      chk({tag, "_latency"}, k, md + ms + mp + 1);
      chk({tag, "_dlyrst_cycles"}, st_dly, md);
      chk({tag, "_setphase_cycles"}, st_phs, mp);
   endtask

   initial begin
      st_dly = 0; st_phs = 0; st_to = 0;
      // reset with GTX_RST held
      repeat (3) cyc(1'b1, 1'b1, 1'b0);
      chk("reset_outputs", int'(obs), 6'b000100);
      repeat (5) cyc(1'b0, 1'b1, 1'b0);
      chk("gtx_rst_no_done", int'(obs[1]), 0);
      // GTX_RST released, TX_RESETDONE after 10 cycles
      repeat (10) cyc(1'b0, 1'b0, 1'b0);
      run_done("full");
      repeat (5) cyc(1'b0, 1'b0, 1'b1);
      // drop at the 100th PhsAlign cycle
      cyc(1'b0, 1'b0, 1'b0);
      repeat (md + ms + 100) cyc(1'b0, 1'b0, 1'b1);
      chk("phs_before_drop", int'(obs[4]), 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("setphase_after_drop", int'(obs[4]), 0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      run_done("rerise");
      // GTX_RST pulse while done
      cyc(1'b0, 1'b1, 1'b1);
      chk("gtx_pulse_done_low", int'(obs[1]), 0);
      cyc(1'b0, 1'b0, 1'b1);
      run_done("after_gtx");
      // random drop points
      repeat (3) begin
         cyc(1'b0, 1'b0, 1'b0);
         n = $urandom_range(0, md + ms + mp + 5);
         repeat (n) cyc(1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0);
         repeat ($urandom_range(1, 5)) cyc(1'b0, 1'b0, 1'b0);
      end
      // RST mid-sequence
      repeat (30) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("rst_mid_seq", int'(obs), 6'b000100);
      // random stimulus on the default DUT
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < 97));

      // short-parameter DUT
      sel = 1; md = 1; ms = 1; mp = 1; mt = 100;
      repeat (3) cyc(1'b1, 1'b1, 1'b0);
      st_to = 0;
      repeat (351) cyc(1'b0, 1'b0, 1'b0);
      chk("timeout_pulses", st_to, TO_EN ? 3 : 0);
      run_done("short");
      for (int i = 0; i < 2000; i++)
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) != 0));
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      repeat (220) cyc(1'b0, 1'b0, 1'b0);
      run_done("short_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
